systolic_gemm_engine: RTL

Output-stationary ROWS x COLS systolic matrix-multiply engine computing C = A x B for A of ROWS x K and B of K x COLS, with K selectable per job at run time.
Operands stream in one K-beat at a time over a valid/ready handshake; internal skew registers feed the PE grid.
Results drain one row per beat over a second valid/ready handshake.
It generalises the fixed-size square array with non-square geometry, run-time K, signed/unsigned mode, a wide accumulator, input bubbles and output backpressure.

---
 rtl/systolic_gemm_engine.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/systolic_gemm_engine.sv
// Output-stationary ROWS x COLS systolic GEMM engine: C = A x B with run-time K,
// operands streamed per K-beat and results drained one row per handshake.
module systolic_gemm_engine #(
  parameter int DATAWIDTH = 16,
  parameter int ROWS      = 4,
  parameter int COLS      = 4,
  parameter int ACCW      = 40,
  parameter int KW        = 8,
  localparam int RW       = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [KW-1:0]             k_len,
  input  logic                      signed_mode,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ROWS*DATAWIDTH-1:0] a_in,
  input  logic [COLS*DATAWIDTH-1:0] b_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [RW-1:0]             out_row,
  output logic [COLS*ACCW-1:0]      c_out,
  output logic                      busy,
  output logic                      done
);
  localparam int FW = $clog2(ROWS + COLS);
  localparam int PW = 2*DATAWIDTH + 2;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FLUSH, S_DRAIN, S_DONE} state_t;

  state_t          state, state_nx;
  logic [KW-1:0]   k_q, beat_q;
  logic            sm_q;
  logic [FW-1:0]   flush_q;
  logic [RW-1:0]   row_q;
  logic            take, clr, last_beat, flush_end, last_row;

  logic [DATAWIDTH-1:0]   a_pe [ROWS][COLS];
  logic [DATAWIDTH-1:0]   b_pe [ROWS][COLS];
  logic signed [ACCW-1:0] acc  [ROWS][COLS];

  // One extra bit per operand carries either the sign or a zero, so a single
  // signed multiplier serves both modes; the cast then wraps or extends to ACCW.
  function automatic logic signed [ACCW-1:0] mac_term(input logic [DATAWIDTH-1:0] a,
                                                       input logic [DATAWIDTH-1:0] b,
                                                       input logic sm);
    logic signed [PW-1:0] ae, be, p;
    ae = {{(DATAWIDTH+2){sm & a[DATAWIDTH-1]}}, a};
    be = {{(DATAWIDTH+2){sm & b[DATAWIDTH-1]}}, b};
    p  = ae * be;
    return ACCW'(p);
  endfunction

  assign last_beat = (beat_q == k_q - 1'b1);
  assign flush_end = (flush_q == FW'(ROWS + COLS - 1));
  assign last_row  = (row_q == RW'(ROWS - 1));
  assign busy      = (state != S_IDLE);
  assign out_row   = row_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    done      = 1'b0;
    take      = 1'b0;
    clr       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          clr      = 1'b1;
          state_nx = (k_len == '0) ? S_FLUSH : S_LOAD;
        end
      end
      S_LOAD: begin
        in_ready = 1'b1;
        take     = in_valid;
        if (in_valid && last_beat) state_nx = S_FLUSH;
      end
      S_FLUSH: if (flush_end) state_nx = S_DRAIN;
      S_DRAIN: begin
        out_valid = 1'b1;
        if (out_ready && last_row) state_nx = S_DONE;
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q     <= '0;
      sm_q    <= 1'b0;
      beat_q  <= '0;
      flush_q <= '0;
      row_q   <= '0;
    end else begin
      if (clr) begin
        k_q    <= k_len;
        sm_q   <= signed_mode;
        beat_q <= '0;
      end else if (take) begin
        beat_q <= beat_q + 1'b1;
      end
      flush_q <= (state == S_FLUSH) ? flush_q + 1'b1 : '0;
      if (state != S_DRAIN)  row_q <= '0;
      else if (out_ready)    row_q <= last_row ? '0 : row_q + 1'b1;
    end
  end

  // Stage 0 registers the gated beat; each lane's chain then covers its skew
  // plus the PE-to-PE forwarding, so PE(r,c) taps stage r+c of both chains.
  for (genvar r = 0; r < ROWS; r++) begin : g_arow
    logic [DATAWIDTH-1:0] a_p [r+COLS];
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < r + COLS; i++) a_p[i] <= '0;
      end else begin
        a_p[0] <= take ? a_in[r*DATAWIDTH +: DATAWIDTH] : '0;
        for (int i = 1; i < r + COLS; i++) a_p[i] <= a_p[i-1];
      end
    end
    for (genvar c = 0; c < COLS; c++) begin : g_tap
      assign a_pe[r][c] = a_p[r+c];
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_bcol
    logic [DATAWIDTH-1:0] b_p [c+ROWS];
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < c + ROWS; i++) b_p[i] <= '0;
      end else begin
        b_p[0] <= take ? b_in[c*DATAWIDTH +: DATAWIDTH] : '0;
        for (int i = 1; i < c + ROWS; i++) b_p[i] <= b_p[i-1];
      end
    end
    for (genvar r = 0; r < ROWS; r++) begin : g_tap
      assign b_pe[r][c] = b_p[c+r];
    end
    assign c_out[c*ACCW +: ACCW] = acc[row_q][c];
  end

  // Accumulators run every cycle; zeros in the chains keep them stable outside LOAD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) acc[r][c] <= '0;
    end else begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          acc[r][c] <= clr ? '0 : acc[r][c] + mac_term(a_pe[r][c], b_pe[r][c], sm_q);
    end
  end

endmodule
